// File: rtl/hash_table_pkg.sv
// Shared types for the hash table command master and its benches.
// Op, status and FSM state encodings plus a saturating counter helper.
package hash_table_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_OK_COLLISION = 3'd1,
    ST_HIT          = 3'd2,
    ST_MISS         = 3'd3,
    ST_FULL         = 3'd4,
    ST_TIMEOUT      = 3'd5,
    ST_ILLEGAL      = 3'd6
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == CNT16_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hash_table_timeout_cnt.sv
// Reloadable down-counter; expire is high once CYCLES enabled
// cycles have elapsed since the last clear.
module hash_table_timeout_cnt #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/hash_table_cmd_master.sv
// Serialising command front end for the hash table: one op in
// flight, registered strobes, timeout-protected response stream.
module hash_table_cmd_master
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_op,
  output logic [2:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic                   tbl_wr_en,
  output logic [KEY_WIDTH-1:0]   tbl_wr_key,
  output logic [VALUE_WIDTH-1:0] tbl_wr_value,
  input  logic                   tbl_wr_done,
  input  logic                   tbl_wr_collision,
  output logic                   tbl_rd_en,
  output logic [KEY_WIDTH-1:0]   tbl_rd_key,
  input  logic [VALUE_WIDTH-1:0] tbl_rd_value,
  input  logic                   tbl_rd_valid,
  input  logic                   tbl_rd_miss,
  output logic                   tbl_del_en,
  output logic [KEY_WIDTH-1:0]   tbl_del_key,
  input  logic                   tbl_del_done,
  output logic [15:0]            timeout_count
);

  state_t                   state;
  op_t                      op_q;
  op_t                      cmd_op_e;
  logic                     tmo_clear;
  logic                     tmo_run;
  logic                     tmo_expire;
  logic                     wait_done;
  status_t                  wait_status;
  logic [VALUE_WIDTH-1:0]   wait_value;

  assign cmd_op_e  = op_t'(cmd_op);
  assign tmo_clear = (state == S_ISSUE);
  assign tmo_run   = (state == S_WAIT);

  hash_table_timeout_cnt #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_run),
    .expire (tmo_expire)
  );

  // Only the issued op's response lines matter; a real answer
  // on the final wait cycle beats the timeout.
  always_comb begin
    wait_done   = 1'b0;
    wait_status = ST_OK;
    wait_value  = '0;
    unique case (op_q)
      OP_WRITE: begin
        unique case (1'b1)
          (tbl_wr_done && tbl_wr_collision): begin
            wait_done   = 1'b1;
            wait_status = ST_OK_COLLISION;
          end
          (tbl_wr_done && !tbl_wr_collision): begin
            wait_done   = 1'b1;
            wait_status = ST_OK;
          end
          (!tbl_wr_done && tbl_wr_collision): begin
            wait_done   = 1'b1;
            wait_status = ST_FULL;
          end
          default: ;
        endcase
      end
      OP_READ: begin
        if (tbl_rd_valid) begin
          wait_done   = 1'b1;
          wait_status = ST_HIT;
          wait_value  = tbl_rd_value;
        end else if (tbl_rd_miss) begin
          wait_done   = 1'b1;
          wait_status = ST_MISS;
        end
      end
      OP_DELETE: begin
        if (tbl_del_done) begin
          wait_done   = 1'b1;
          wait_status = ST_OK;
        end
      end
      OP_RSVD: ;
    endcase
    if (!wait_done && tmo_expire) begin
      wait_done   = 1'b1;
      wait_status = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= OP_READ;
      cmd_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_op       <= '0;
      resp_status   <= '0;
      resp_value    <= '0;
      tbl_wr_en     <= 1'b0;
      tbl_rd_en     <= 1'b0;
      tbl_del_en    <= 1'b0;
      tbl_wr_key    <= '0;
      tbl_wr_value  <= '0;
      tbl_rd_key    <= '0;
      tbl_del_key   <= '0;
      timeout_count <= '0;
    end else begin
      tbl_wr_en  <= 1'b0;
      tbl_rd_en  <= 1'b0;
      tbl_del_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op_e;
            cmd_ready <= 1'b0;
            unique case (cmd_op_e)
              OP_WRITE: begin
                tbl_wr_en    <= 1'b1;
                tbl_wr_key   <= cmd_key;
                tbl_wr_value <= cmd_value;
                state        <= S_ISSUE;
              end
              OP_READ: begin
                tbl_rd_en  <= 1'b1;
                tbl_rd_key <= cmd_key;
                state      <= S_ISSUE;
              end
              OP_DELETE: begin
                tbl_del_en  <= 1'b1;
                tbl_del_key <= cmd_key;
                state       <= S_ISSUE;
              end
              OP_RSVD: begin
                resp_valid  <= 1'b1;
                resp_op     <= cmd_op;
                resp_status <= ST_ILLEGAL;
                resp_value  <= '0;
                state       <= S_RESP;
              end
            endcase
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_done) begin
            resp_valid  <= 1'b1;
            resp_op     <= op_q;
            resp_status <= wait_status;
            resp_value  <= wait_value;
            state       <= S_RESP;
            if (wait_status == ST_TIMEOUT) begin
              timeout_count <= sat_inc16(timeout_count);
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_cmd_master.sv
// Self-checking bench for hash_table_cmd_master: directed scenarios
// plus randomized commands against a per-command outcome model.
module tb_hash_table_cmd_master;
  import hash_table_pkg::*;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [KW-1:0] cmd_key = '0;
  logic [VW-1:0] cmd_value = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_op;
  logic [2:0]    resp_status;
  logic [VW-1:0] resp_value;
  logic          tbl_wr_en;
  logic [KW-1:0] tbl_wr_key;
  logic [VW-1:0] tbl_wr_value;
  logic          tbl_wr_done = 1'b0;
  logic          tbl_wr_collision = 1'b0;
  logic          tbl_rd_en;
  logic [KW-1:0] tbl_rd_key;
  logic [VW-1:0] tbl_rd_value = '0;
  logic          tbl_rd_valid = 1'b0;
  logic          tbl_rd_miss = 1'b0;
  logic          tbl_del_en;
  logic [KW-1:0] tbl_del_key;
  logic          tbl_del_done = 1'b0;
  logic [15:0]   timeout_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state: last key/value sent per op, timeout tally.
  logic [KW-1:0] m_wr_key  = '0;
  logic [VW-1:0] m_wr_val  = '0;
  logic [KW-1:0] m_rd_key  = '0;
  logic [KW-1:0] m_del_key = '0;
  int            m_tmo     = 0;

  hash_table_cmd_master #(
    .KEY_WIDTH      (KW),
    .VALUE_WIDTH    (VW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_key          (cmd_key),
    .cmd_value        (cmd_value),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_op          (resp_op),
    .resp_status      (resp_status),
    .resp_value       (resp_value),
    .tbl_wr_en        (tbl_wr_en),
    .tbl_wr_key       (tbl_wr_key),
    .tbl_wr_value     (tbl_wr_value),
    .tbl_wr_done      (tbl_wr_done),
    .tbl_wr_collision (tbl_wr_collision),
    .tbl_rd_en        (tbl_rd_en),
    .tbl_rd_key       (tbl_rd_key),
    .tbl_rd_value     (tbl_rd_value),
    .tbl_rd_valid     (tbl_rd_valid),
    .tbl_rd_miss      (tbl_rd_miss),
    .tbl_del_en       (tbl_del_en),
    .tbl_del_key      (tbl_del_key),
    .tbl_del_done     (tbl_del_done),
    .timeout_count    (timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Outcome of one command from the table's answer: which status,
  // what data, and how many edges after accept resp_valid shows.
  function automatic void model(
    input  logic [1:0]  op,
    input  int          resp_at,
    input  bit          wd, wc, rv, rm, dd,
    input  logic [31:0] rdv,
    output logic [2:0]  st,
    output logic [31:0] val,
    output int          lat
  );
    bit ans;
    val = '0;
    if (op == 2'd3) begin
      st  = ST_ILLEGAL;
      lat = 0;
      return;
    end
    ans = (resp_at >= 1) && (resp_at <= T) &&
          ((op == 2'd1 && (wd || wc)) ||
           (op == 2'd0 && (rv || rm)) ||
           (op == 2'd2 && dd));
    if (!ans) begin
      st  = ST_TIMEOUT;
      lat = T + 1;
      return;
    end
    lat = resp_at + 1;
    case (op)
      2'd1:    st = wd ? (wc ? ST_OK_COLLISION : ST_OK) : ST_FULL;
      2'd0:    begin
        st  = rv ? ST_HIT : ST_MISS;
        val = rv ? rdv : '0;
      end
      default: st = ST_OK;
    endcase
  endfunction

  task automatic model_commit(
    input logic [1:0]  op,
    input logic [31:0] key,
    input logic [31:0] value,
    input logic [2:0]  st
  );
    case (op)
      2'd0: m_rd_key = key;
      2'd1: begin
        m_wr_key = key;
        m_wr_val = value;
      end
      2'd2: m_del_key = key;
      default: ;
    endcase
    if (st == ST_TIMEOUT && m_tmo < 65535) m_tmo++;
  endtask

  task automatic clear_tbl();
    tbl_wr_done      = 1'b0;
    tbl_wr_collision = 1'b0;
    tbl_rd_valid     = 1'b0;
    tbl_rd_miss      = 1'b0;
    tbl_del_done     = 1'b0;
  endtask

  // Drives one command and plays the table; returns observations.
  task automatic do_cmd(
    input  logic [1:0]  op,
    input  logic [31:0] key,
    input  logic [31:0] value,
    input  int          resp_at,
    input  bit          wd, wc, rv, rm, dd,
    input  logic [31:0] rdv,
    input  bit          noise,
    input  int          ready_delay,
    input  bit          early,
    output int          lat,
    output logic [1:0]  o_op,
    output logic [2:0]  o_st,
    output logic [31:0] o_val,
    output int          n_en,
    output int          multi,
    output bit          en_ok,
    output bit          stable,
    output bit          post_ok,
    output int          acc_cyc
  );
    int w;
    int e;
    int ens;
    lat = -1; o_op = '0; o_st = '0; o_val = '0;
    n_en = 0; multi = 0; en_ok = 0; stable = 1;
    post_ok = 0; acc_cyc = 0;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_key    = key;
    cmd_value  = value;
    resp_ready = early;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_key   = $urandom;
    cmd_value = $urandom;
    for (e = 0; e <= T + 8; e++) begin
      ens = int'(tbl_wr_en) + int'(tbl_rd_en) + int'(tbl_del_en);
      n_en += ens;
      if (ens > 1) multi++;
      if (e == 0) begin
        case (op)
          2'd0: en_ok = tbl_rd_en === 1'b1 && ens == 1;
          2'd1: en_ok = tbl_wr_en === 1'b1 && ens == 1;
          2'd2: en_ok = tbl_del_en === 1'b1 && ens == 1;
          default: en_ok = ens == 0;
        endcase
      end
      if (resp_valid === 1'b1) begin
        lat = e;
        break;
      end
      clear_tbl();
      tbl_rd_value = $urandom;
      if (noise) begin
        if (op != 2'd1) begin
          tbl_wr_done      = 1'b1;
          tbl_wr_collision = 1'($urandom);
        end
        if (op != 2'd0) tbl_rd_valid = 1'b1;
        if (op != 2'd2) tbl_del_done = 1'b1;
      end
      if (resp_at > 0 && e == resp_at) begin
        case (op)
          2'd0: begin
            tbl_rd_valid = rv;
            tbl_rd_miss  = rm;
            tbl_rd_value = rdv;
          end
          2'd1: begin
            tbl_wr_done      = wd;
            tbl_wr_collision = wc;
          end
          2'd2: tbl_del_done = dd;
          default: ;
        endcase
      end
      @(posedge clk); #1;
    end
    clear_tbl();
    if (lat < 0) begin
      resp_ready = 1'b0;
      return;
    end
    o_op  = resp_op;
    o_st  = resp_status;
    o_val = resp_value;
    if (!early) begin
      for (int d = 0; d < ready_delay; d++) begin
        @(posedge clk); #1;
        if (resp_valid !== 1'b1 || resp_op !== o_op ||
            resp_status !== o_st || resp_value !== o_val ||
            cmd_ready !== 1'b0)
          stable = 0;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    post_ok = resp_valid === 1'b0 && cmd_ready === 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hs: got rdy=%b vld=%b want 1/0",
               cmd_ready, resp_valid);
    end
    n_checks++;
    if ({tbl_wr_en, tbl_rd_en, tbl_del_en} !== 3'b000 ||
        tbl_wr_key !== '0 || tbl_rd_key !== '0 ||
        tbl_del_key !== '0 || tbl_wr_value !== '0) begin
      n_fail++;
      $display("FAIL rst_tbl: got en=%b%b%b wk=%h want 0",
               tbl_wr_en, tbl_rd_en, tbl_del_en, tbl_wr_key);
    end
    n_checks++;
    if (resp_op !== '0 || resp_status !== '0 ||
        resp_value !== '0 || timeout_count !== '0) begin
      n_fail++;
      $display("FAIL rst_resp: got op=%0d st=%0d v=%h tc=%0d want 0",
               resp_op, resp_status, resp_value, timeout_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_ok();
    int lat, n_en, multi, acc;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok;
    do_cmd(2'd1, 32'h1234, 32'hCAFE, 1, 1, 0, 0, 0, 0, '0,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd1, 32'h1234, 32'hCAFE, ST_OK);
    n_checks++;
    if (lat !== 2 || o_st !== ST_OK || o_op !== 2'd1) begin
      n_fail++;
      $display("FAIL wr_ok: got lat=%0d st=%0d op=%0d want 2/0/1",
               lat, o_st, o_op);
    end
    n_checks++;
    if (!en_ok || n_en != 1 || multi != 0) begin
      n_fail++;
      $display("FAIL wr_ok_pulse: got ok=%0d n=%0d want 1/1",
               en_ok, n_en);
    end
    n_checks++;
    if (tbl_wr_key !== m_wr_key || tbl_wr_value !== m_wr_val ||
        !post_ok) begin
      n_fail++;
      $display("FAIL wr_ok_data: got k=%h v=%h post=%0d want %h/%h/1",
               tbl_wr_key, tbl_wr_value, post_ok, m_wr_key, m_wr_val);
    end
  endtask

  task automatic test_read();
    int lat, n_en, multi, acc;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok;
    do_cmd(2'd0, 32'h1234, 32'h0BAD, 1, 0, 0, 1, 0, 0, 32'hCAFE,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd0, 32'h1234, 32'h0BAD, ST_HIT);
    n_checks++;
    if (o_st !== ST_HIT || o_val !== 32'hCAFE || lat !== 2 ||
        o_op !== 2'd0) begin
      n_fail++;
      $display("FAIL rd_hit: got st=%0d v=%h lat=%0d want 2/cafe/2",
               o_st, o_val, lat);
    end
    do_cmd(2'd0, 32'h9999, 32'hDEAD, 1, 0, 0, 0, 1, 0, 32'h5555,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd0, 32'h9999, 32'hDEAD, ST_MISS);
    n_checks++;
    if (o_st !== ST_MISS || o_val !== '0 || !en_ok) begin
      n_fail++;
      $display("FAIL rd_miss: got st=%0d v=%h want 3/0", o_st, o_val);
    end
    n_checks++;
    if (tbl_rd_key !== m_rd_key || tbl_wr_value !== m_wr_val) begin
      n_fail++;
      $display("FAIL rd_keys: got rk=%h wv=%h want %h/%h",
               tbl_rd_key, tbl_wr_value, m_rd_key, m_wr_val);
    end
  endtask

  task automatic test_write_flags();
    int lat, n_en, multi, acc;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok;
    do_cmd(2'd1, 32'h77, 32'h11, 1, 0, 1, 0, 0, 0, '0,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd1, 32'h77, 32'h11, ST_FULL);
    n_checks++;
    if (o_st !== ST_FULL) begin
      n_fail++;
      $display("FAIL wr_full: got %0d want 4", o_st);
    end
    do_cmd(2'd1, 32'h78, 32'h22, 1, 1, 1, 0, 0, 0, '0,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd1, 32'h78, 32'h22, ST_OK_COLLISION);
    n_checks++;
    if (o_st !== ST_OK_COLLISION || tbl_wr_value !== m_wr_val) begin
      n_fail++;
      $display("FAIL wr_coll: got st=%0d wv=%h want 1/%h",
               o_st, tbl_wr_value, m_wr_val);
    end
  endtask

  task automatic test_timeout();
    int lat, n_en, multi, acc;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok, quiet;
    do_cmd(2'd2, 32'hABCD, 32'h0, 0, 0, 0, 0, 0, 0, '0,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd2, 32'hABCD, 32'h0, ST_TIMEOUT);
    n_checks++;
    if (o_st !== ST_TIMEOUT || lat !== T + 1 || o_op !== 2'd2) begin
      n_fail++;
      $display("FAIL tmo: got st=%0d lat=%0d want 5/%0d",
               o_st, lat, T + 1);
    end
    n_checks++;
    if (timeout_count !== 16'(m_tmo)) begin
      n_fail++;
      $display("FAIL tmo_cnt: got %0d want %0d", timeout_count, m_tmo);
    end
    quiet = 1;
    tbl_del_done = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 0;
    end
    tbl_del_done = 1'b0;
    n_checks++;
    if (!quiet || timeout_count !== 16'(m_tmo)) begin
      n_fail++;
      $display("FAIL late_del: got quiet=%0d tc=%0d want 1/%0d",
               quiet, timeout_count, m_tmo);
    end
    // Answer on the very last wait cycle still counts.
    do_cmd(2'd0, 32'h4242, 32'h0, T, 0, 0, 1, 0, 0, 32'h600D,
           0, 0, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    model_commit(2'd0, 32'h4242, 32'h0, ST_HIT);
    n_checks++;
    if (o_st !== ST_HIT || lat !== T + 1 || o_val !== 32'h600D ||
        timeout_count !== 16'(m_tmo)) begin
      n_fail++;
      $display("FAIL tmo_edge: got st=%0d lat=%0d tc=%0d want 2/%0d/%0d",
               o_st, lat, timeout_count, T + 1, m_tmo);
    end
  endtask

  task automatic test_illegal();
    int lat, n_en, multi, acc;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok;
    do_cmd(2'd3, 32'h5A5A, 32'hFFFF, 1, 1, 1, 1, 1, 1, 32'h1,
           1, 5, 0, lat, o_op, o_st, o_val,
           n_en, multi, en_ok, stable, post_ok, acc);
    n_checks++;
    if (o_st !== ST_ILLEGAL || o_op !== 2'd3 || lat !== 0 ||
        o_val !== '0) begin
      n_fail++;
      $display("FAIL illegal: got st=%0d op=%0d lat=%0d want 6/3/0",
               o_st, o_op, lat);
    end
    n_checks++;
    if (n_en != 0) begin
      n_fail++;
      $display("FAIL illegal_en: got %0d strobes want 0", n_en);
    end
    n_checks++;
    if (!stable || !post_ok) begin
      n_fail++;
      $display("FAIL illegal_hold: got stable=%0d post=%0d want 1/1",
               stable, post_ok);
    end
  endtask

  task automatic test_back_to_back();
    int lat, n_en, multi, acc, prev;
    logic [1:0] o_op;
    logic [2:0] o_st;
    logic [31:0] o_val;
    bit en_ok, stable, post_ok;
    logic [31:0] k;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      k = $urandom;
      do_cmd(2'd0, k, 32'h0, 1, 0, 0, 1, 0, 0, k ^ 32'hFFFF,
             0, 0, 1, lat, o_op, o_st, o_val,
             n_en, multi, en_ok, stable, post_ok, acc);
      model_commit(2'd0, k, 32'h0, ST_HIT);
      n_checks++;
      if (lat !== 2 || o_val !== (k ^ 32'hFFFF) || !post_ok) begin
        n_fail++;
        $display("FAIL b2b_resp: got lat=%0d v=%h want 2/%h",
                 lat, o_val, k ^ 32'hFFFF);
      end
      if (prev >= 0) begin
        n_checks++;
        if (acc - prev != 4) begin
          n_fail++;
          $display("FAIL b2b_rate: got %0d cycles want 4", acc - prev);
        end
      end
      prev = acc;
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_key   = 32'h3131;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 ||
        tbl_rd_en !== 1'b0 || tbl_rd_key !== '0 ||
        tbl_wr_value !== '0 || timeout_count !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got rdy=%b vld=%b rk=%h tc=%0d want 1/0/0/0",
               cmd_ready, resp_valid, tbl_rd_key, timeout_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_wr_key = '0; m_wr_val = '0; m_rd_key = '0;
    m_del_key = '0; m_tmo = 0;
    tbl_rd_valid = 1'b1;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tbl_rd_valid = 1'b0;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rst_mid_late: got a response or busy, want idle");
    end
  endtask

  task automatic test_random();
    int lat, n_en, multi, acc, e_lat, r, resp_at, rd_dly;
    logic [1:0] op, o_op;
    logic [2:0] o_st, e_st;
    logic [31:0] o_val, e_val, key, val, rdv;
    bit en_ok, stable, post_ok, noise, wd, wc, rv, rm, dd;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      key = $urandom;
      val = $urandom;
      rdv = $urandom;
      r = $urandom_range(0, 9);
      resp_at = (r == 0) ? 0 : (r < 7) ? 1 : $urandom_range(2, T);
      r  = $urandom_range(0, 2);
      wd = r != 1;
      wc = r != 0;
      rv = $urandom_range(0, 1) == 1;
      rm = !rv;
      dd = 1;
      noise  = $urandom_range(0, 1) == 1;
      rd_dly = $urandom_range(0, 3);
      model(op, resp_at, wd, wc, rv, rm, dd, rdv, e_st, e_val, e_lat);
      do_cmd(op, key, val, resp_at, wd, wc, rv, rm, dd, rdv,
             noise, rd_dly, 0, lat, o_op, o_st, o_val,
             n_en, multi, en_ok, stable, post_ok, acc);
      model_commit(op, key, val, e_st);
      n_checks++;
      if (o_st !== e_st || o_val !== e_val || o_op !== op ||
          lat !== e_lat) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: got st=%0d v=%h op=%0d lat=%0d want %0d/%h/%0d/%0d",
                 i, o_st, o_val, o_op, lat, e_st, e_val, op, e_lat);
      end
      n_checks++;
      if (!en_ok || multi != 0 || n_en != ((op == 2'd3) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL rnd_en[%0d]: got ok=%0d n=%0d multi=%0d op=%0d",
                 i, en_ok, n_en, multi, op);
      end
      n_checks++;
      if (!stable || !post_ok || timeout_count !== 16'(m_tmo)) begin
        n_fail++;
        $display("FAIL rnd_hs[%0d]: got stable=%0d post=%0d tc=%0d want 1/1/%0d",
                 i, stable, post_ok, timeout_count, m_tmo);
      end
      n_checks++;
      if (tbl_wr_key !== m_wr_key || tbl_wr_value !== m_wr_val ||
          tbl_rd_key !== m_rd_key || tbl_del_key !== m_del_key) begin
        n_fail++;
        $display("FAIL rnd_keys[%0d]: got %h/%h/%h/%h want %h/%h/%h/%h",
                 i, tbl_wr_key, tbl_wr_value, tbl_rd_key, tbl_del_key,
                 m_wr_key, m_wr_val, m_rd_key, m_del_key);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_ok();
    test_read();
    test_write_flags();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
